// File: rtl/branch_outcome_checker.sv
// Branch resolution tracker: computes actual outcomes at issue, queues them in order and pairs
// each with its returning prediction to flag mispredicts and keep saturating totals.
module branch_outcome_checker #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [1:0]                 op,
  input  logic [DW-1:0]              A,
  input  logic [DW-1:0]              B,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic                       clr,
  output logic                       res_valid,
  output logic                       res_taken,
  output logic                       res_mispredict,
  output logic [1:0]                 res_op,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic                       overflow,
  output logic                       orphan
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e          state_q, state_d;
  logic [2:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   pending_q;
  logic            res_valid_q, res_taken_q, res_mis_q;
  logic [1:0]      res_op_q;
  logic [CNT_W-1:0] total_q, miss_q;
  logic            overflow_q, orphan_q;

  logic actual, push, pop, full, empty, head_actual, mis;

  always_comb begin
    actual = 1'b0;
    unique case (op)
      2'b00: actual = (A == B);
      2'b01: actual = (A != B);
      2'b10: actual = (A < B);
      2'b11: actual = (A >= B);
      default: actual = 1'b0;
    endcase
  end

  assign full        = (state_q == StFull);
  assign empty       = (state_q == StEmpty);
  assign pop         = pred_valid && !empty;
  // A pop frees the head slot on the same edge, so a full queue still accepts the push.
  assign push        = in_valid && (!full || pop);
  assign head_actual = mem_q[rd_ptr_q][0];
  assign mis         = pred_taken != head_actual;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:   if (push) state_d = StPartial;
      StPartial: begin
        if (push && !pop && pending_q == CW'(DEPTH - 1)) state_d = StFull;
        else if (pop && !push && pending_q == CW'(1))    state_d = StEmpty;
      end
      StFull:    if (pop && !push) state_d = StPartial;
      default:   state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StEmpty;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {op, actual};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      pending_q <= pending_q + CW'(1);
      else if (pop && !push) pending_q <= pending_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mis_q   <= 1'b0;
      res_op_q    <= '0;
    end else begin
      res_valid_q <= pop;
      if (pop) begin
        res_taken_q <= head_actual;
        res_op_q    <= mem_q[rd_ptr_q][2:1];
        res_mis_q   <= mis;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q    <= '0;
      miss_q     <= '0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else if (clr) begin
      total_q    <= '0;
      miss_q     <= '0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      if (pop && total_q != '1)        total_q <= total_q + CNT_W'(1);
      if (pop && mis && miss_q != '1)  miss_q  <= miss_q + CNT_W'(1);
      if (in_valid && full && !pop)    overflow_q <= 1'b1;
      if (pred_valid && empty)         orphan_q   <= 1'b1;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mis_q;
  assign res_op         = res_op_q;
  assign pending        = pending_q;
  assign total_cnt      = total_q;
  assign miss_cnt       = miss_q;
  assign overflow       = overflow_q;
  assign orphan         = orphan_q;

endmodule
